// File: rtl/display_capture_if.sv
// Scanned 7-segment bus toward the capture block, rebuilt BCD digits and status flags back out.
interface display_capture_if;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic [15:0] DIGITOS;
  logic        VALID;
  logic        ERR;
  logic        STALL;

  modport master (output SEG, AN, input DIGITOS, VALID, ERR, STALL);
  modport slave  (input SEG, AN, output DIGITOS, VALID, ERR, STALL);
endinterface

// File: rtl/display_capture.sv
// Rebuilds the four BCD digits from a multiplexed 7-segment scan and publishes them once per frame.
// Defining DISPLAY_CAPTURE_TIMEOUT_EN adds a watchdog that raises STALL when frames stop completing.
module display_capture #(
  parameter int SETTLE      = 1000,
  parameter int BITS        = 10,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1,
  parameter int TIMEOUT     = 1_000_000,
  parameter int TO_BITS     = 20
) (
  input logic              CLK,
  input logic              RST,
  display_capture_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_HOLD} state_t;

  localparam logic [BITS-1:0] CNT_LAST = BITS'(SETTLE - 2);

  logic [6:0]      seg_s1, seg_s2, seg_n, cap_seg;
  logic [3:0]      an_s1, an_s2, an_n, cap_an;
  logic [10:0]     prev_pat;
  logic            changed, onehot;
  state_t          state;
  logic [BITS-1:0] cnt;
  logic [15:0]     shadow, digitos;
  logic [3:0]      mask, mask_nxt, cap_val;
  logic            frame_err, err_nxt, err, valid;
  logic            capture, publish, cap_bad, clear;

  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 4'd0;
      7'b0110000: decode = 4'd1;
      7'b1101101: decode = 4'd2;
      7'b1111001: decode = 4'd3;
      7'b0110011: decode = 4'd4;
      7'b1011011: decode = 4'd5;
      7'b1011111: decode = 4'd6;
      7'b1110000: decode = 4'd7;
      7'b1111111: decode = 4'd8;
      7'b1111011: decode = 4'd9;
      default:    decode = 4'hF;
    endcase
  endfunction

  always_comb begin
    seg_n   = (SEG_ACT_LOW != 0) ? ~seg_s2 : seg_s2;
    an_n    = (AN_ACT_LOW != 0) ? ~an_s2 : an_s2;
    onehot  = (an_n != 4'd0) && ((an_n & (an_n - 4'd1)) == 4'd0);
    changed = ({an_n, seg_n} != prev_pat);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      seg_s1   <= '0;
      seg_s2   <= '0;
      an_s1    <= '0;
      an_s2    <= '0;
      prev_pat <= '0;
    end else begin
      seg_s1   <= bus.SEG;
      seg_s2   <= seg_s1;
      an_s1    <= bus.AN;
      an_s2    <= an_s1;
      prev_pat <= {an_n, seg_n};
    end
  end

  // The sampled pattern is frozen on the way into CAPTURE so a change on that same edge cannot corrupt it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cap_an  <= '0;
      cap_seg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (onehot) begin
            cnt   <= '0;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!onehot) begin
            state <= S_IDLE;
          end else if (changed) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state   <= S_CAPTURE;
              cap_an  <= an_n;
              cap_seg <= seg_n;
            end
          end
        end
        S_CAPTURE: state <= S_HOLD;
        S_HOLD: begin
          if ({an_n, seg_n} != {cap_an, cap_seg}) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign capture = (state == S_CAPTURE);
  assign publish = (mask == 4'hF);
  assign cap_val = decode(cap_seg);
  assign cap_bad = (cap_val == 4'hF);

  always_comb begin
    mask_nxt = (publish || clear) ? 4'd0 : mask;
    err_nxt  = publish ? 1'b0 : frame_err;
    if (capture) begin
      mask_nxt = mask_nxt | cap_an;
      err_nxt  = err_nxt | cap_bad;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mask      <= '0;
      frame_err <= 1'b0;
      shadow    <= '0;
      digitos   <= '0;
      err       <= 1'b0;
      valid     <= 1'b0;
    end else begin
      mask      <= mask_nxt;
      frame_err <= err_nxt;
      valid     <= publish;
      if (publish) begin
        digitos <= shadow;
        err     <= frame_err;
      end
      if (capture) begin
        for (int i = 0; i < 4; i++) begin
          if (cap_an[i]) shadow[4*i +: 4] <= cap_val;
        end
      end
    end
  end

  assign bus.DIGITOS = digitos;
  assign bus.VALID   = valid;
  assign bus.ERR     = err;

`ifdef DISPLAY_CAPTURE_TIMEOUT_EN
  logic [TO_BITS-1:0] wd;
  logic               stall;

  // Fires on the edge where the counter would reach TIMEOUT-1, then restarts from zero.
  assign clear = (wd == TO_BITS'(TIMEOUT - 2)) && !publish;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wd    <= '0;
      stall <= 1'b0;
    end else if (publish) begin
      wd    <= '0;
      stall <= 1'b0;
    end else if (clear) begin
      wd    <= '0;
      stall <= 1'b1;
    end else begin
      wd <= wd + 1'b1;
    end
  end

  assign bus.STALL = stall;
`else
  assign clear     = 1'b0;
  assign bus.STALL = 1'b0;
`endif

endmodule

// File: tb/tb_display_capture.sv
// Randomized bench for display_capture: a dwell-level reference model predicts every published frame.
module tb_display_capture;

  logic CLK, RST;

  display_capture_if bus();

  display_capture #(
    .SETTLE(4), .BITS(3), .SEG_ACT_LOW(1), .AN_ACT_LOW(1), .TIMEOUT(1_000_000), .TO_BITS(20)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

`ifdef DISPLAY_CAPTURE_TIMEOUT_EN
  display_capture_if wd_bus();
  assign wd_bus.SEG = bus.SEG;
  assign wd_bus.AN  = bus.AN;

  display_capture #(
    .SETTLE(4), .BITS(3), .SEG_ACT_LOW(1), .AN_ACT_LOW(1), .TIMEOUT(50), .TO_BITS(6)
  ) wd_dut (
    .CLK(CLK), .RST(RST), .bus(wd_bus)
  );
`endif

  int          total, bad, valid_count, frames_expected;
  logic [16:0] exp_q[$];
  logic [6:0]  seg_table[10];
  logic [3:0]  shadow_m[4];
  logic [3:0]  mask_m;
  logic        err_m;
  logic [10:0] last_pat;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFrames(input string tag);
    checkOutput(tag, valid_count, frames_expected);
  endtask

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    ref_decode = 4'hF;
    for (int k = 0; k < 10; k++) if (seg_table[k] == s) ref_decode = 4'(k);
  endfunction

  // A dwell of at least 6 cycles on one digit is a capture; dwells of 3 or fewer never are.
  task automatic model_dwell(input logic [3:0] an_norm, input logic [6:0] seg_norm, input int cycles);
    logic [3:0] val;
    if ({an_norm, seg_norm} == last_pat || cycles < 6 || !$onehot(an_norm)) return;
    val = ref_decode(seg_norm);
    for (int i = 0; i < 4; i++) begin
      if (an_norm[i]) begin
        shadow_m[i] = val;
        mask_m[i]   = 1'b1;
      end
    end
    if (val == 4'hF) err_m = 1'b1;
    if (mask_m == 4'hF) begin
      exp_q.push_back({err_m, shadow_m[3], shadow_m[2], shadow_m[1], shadow_m[0]});
      frames_expected++;
      mask_m = 4'd0;
      err_m  = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] an_norm, input logic [6:0] seg_norm, input int cycles);
    bus.AN  = ~an_norm;
    bus.SEG = ~seg_norm;
    model_dwell(an_norm, seg_norm, cycles);
    last_pat = {an_norm, seg_norm};
    repeat (cycles) @(negedge CLK);
    if (cycles >= 10) checkFrames("framesAfterDwell");
  endtask

  task automatic scanFrame(input logic [15:0] digits, input int cycles);
    for (int i = 3; i >= 0; i--) applyStimulus(4'(1 << i), seg_table[digits[4*i +: 4]], cycles);
  endtask

  task automatic model_reset();
    mask_m   = 4'd0;
    err_m    = 1'b0;
    last_pat = 11'h7FF;
  endtask

  always @(negedge CLK) begin
    if (RST && bus.VALID) begin
      logic [16:0] exp_frame;
      valid_count++;
      if (exp_q.size() == 0) begin
        checkOutput("extraValid", valid_count, frames_expected);
      end else begin
        exp_frame = exp_q.pop_front();
        checkOutput("frameDigitos", bus.DIGITOS, exp_frame[15:0]);
        checkOutput("frameErr", bus.ERR, exp_frame[16]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL simTimeout observed=%0t required=<1000000", $time);
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    logic [3:0] an_r;
    logic [6:0] seg_r;
    total = 0; bad = 0; valid_count = 0; frames_expected = 0;
    seg_table[0] = 7'b1111110; seg_table[1] = 7'b0110000; seg_table[2] = 7'b1101101;
    seg_table[3] = 7'b1111001; seg_table[4] = 7'b0110011; seg_table[5] = 7'b1011011;
    seg_table[6] = 7'b1011111; seg_table[7] = 7'b1110000; seg_table[8] = 7'b1111111;
    seg_table[9] = 7'b1111011;
    for (int i = 0; i < 4; i++) shadow_m[i] = 4'd0;
    model_reset();

    RST     = 1'b1;
    bus.AN  = 4'hF;
    bus.SEG = 7'h7F;
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rstDigitos", bus.DIGITOS, 16'h0000);
    checkOutput("rstValid", bus.VALID, 1'b0);
    checkOutput("rstErr", bus.ERR, 1'b0);
    checkOutput("rstStall", bus.STALL, 1'b0);
    RST = 1'b1;

`ifdef DISPLAY_CAPTURE_TIMEOUT_EN
    repeat (48) @(negedge CLK);
    checkOutput("stallEarly", wd_bus.STALL, 1'b0);
    @(negedge CLK);
    checkOutput("stallSet", wd_bus.STALL, 1'b1);
    repeat (11) @(negedge CLK);
    scanFrame(16'h4321, 8);
    applyStimulus(4'h0, 7'h00, 4);
    checkOutput("wdDigitos", wd_bus.DIGITOS, 16'h4321);
    checkOutput("stallCleared", wd_bus.STALL, 1'b0);
    checkFrames("wdFrames");
`endif

    $display("[TB] nominal scan");
    scanFrame(16'h5947, 10);
    checkOutput("nominalDigitos", bus.DIGITOS, 16'h5947);
    checkOutput("nominalErr", bus.ERR, 1'b0);

    $display("[TB] glitch rejection");
    applyStimulus(4'b1000, seg_table[1], 10);
    applyStimulus(4'b0100, seg_table[2], 10);
    applyStimulus(4'b0010, seg_table[3], 10);
    for (int g = 0; g < 4; g++) applyStimulus(4'b0001, (g % 2 == 0) ? seg_table[8] : seg_table[0], 3);
    checkFrames("glitchNoValid");
    applyStimulus(4'b0001, seg_table[8], 6);
    applyStimulus(4'h0, 7'h00, 4);
    checkFrames("glitchCapture");
    checkOutput("glitchDigitos", bus.DIGITOS, 16'h1238);

    $display("[TB] bad pattern");
    applyStimulus(4'b1000, seg_table[0], 10);
    applyStimulus(4'b0100, seg_table[8], 10);
    applyStimulus(4'b0010, 7'b0000001, 10);
    applyStimulus(4'b0001, seg_table[2], 10);
    checkOutput("badNibble", bus.DIGITOS[7:4], 4'hF);
    checkOutput("badErr", bus.ERR, 1'b1);
    checkOutput("badDigitos", bus.DIGITOS, 16'h08F2);
    scanFrame(16'h1357, 10);
    checkOutput("cleanErr", bus.ERR, 1'b0);

    $display("[TB] multi-hot anodes");
    applyStimulus(4'b1000, seg_table[9], 10);
    applyStimulus(4'b0100, seg_table[6], 10);
    applyStimulus(4'b0011, seg_table[8], 20);
    applyStimulus(4'b0010, seg_table[4], 10);
    applyStimulus(4'b0001, seg_table[1], 10);
    checkOutput("multiHotDigitos", bus.DIGITOS, 16'h9641);

    $display("[TB] reset mid-frame");
    applyStimulus(4'b1000, seg_table[7], 10);
    applyStimulus(4'b0100, seg_table[3], 10);
    #2 RST = 1'b0;
    #1;
    checkOutput("midRstDigitos", bus.DIGITOS, 16'h0000);
    checkOutput("midRstValid", bus.VALID, 1'b0);
    checkOutput("midRstErr", bus.ERR, 1'b0);
    checkOutput("midRstStall", bus.STALL, 1'b0);
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    scanFrame(16'h2468, 10);
    checkOutput("postRstDigitos", bus.DIGITOS, 16'h2468);

    $display("[TB] randomized dwells");
    for (int n = 0; n < 120; n++) begin
      an_r  = 4'(1 << $urandom_range(0, 3));
      seg_r = ($urandom_range(0, 5) == 0) ? 7'($urandom) : seg_table[$urandom_range(0, 9)];
      applyStimulus(an_r, seg_r, $urandom_range(10, 13));
      if ($urandom_range(0, 3) == 0) applyStimulus(4'h0, 7'h00, $urandom_range(2, 4));
    end
    applyStimulus(4'h0, 7'h00, 12);
    checkFrames("finalFrames");
    checkOutput("stallIdle", bus.STALL, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_capture.md
Name: display_capture

Overview:
- Receive-side counterpart of the clock's multiplexed 7-segment display driver.
- Inputs: scanned segment bus plus anode bus. Outputs: the four BCD digits being displayed, rebuilt and published once per complete scan frame.
- Uses: loopback self-check on the board, and driving a remote display or readout from the captured time.

Parameters:
- SETTLE, 1000: cycles an anode/segment pattern must stay unchanged before it is sampled.
- BITS, 10: width of settle counter; must hold SETTLE.
- SEG_ACT_LOW, 1: 1 = segment bus active-low, 0 = active-high.
- AN_ACT_LOW, 1: 1 = anode bus active-low, 0 = active-high.
- TIMEOUT, 1_000_000: watchdog limit in cycles (optional feature only).
- TO_BITS, 20: width of watchdog counter.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-low.
- SEG  in  7  segment bus; SEG[6]=a … SEG[0]=g.
- AN  in  4  anode bus; AN[i] active selects digit i. Digit 0 = units of seconds, digit 3 = tens of minutes.
- DIGITOS  out  16  captured digits; DIGITOS[4i+3:4i] = digit i.
- VALID  out  1  one-cycle pulse when DIGITOS updates.
- ERR  out  1  frame contained an undecodable segment pattern; valid while VALID=1, held until next VALID.
- STALL  out  1  watchdog flag (optional feature).

Behaviour:
- Reset (RST=0, any time, async): DIGITOS=16'h0000, VALID=0, ERR=0, STALL=0. Clears internal state: synchronizers, counters, capture mask, frame error flag. State returns to IDLE.
- Input conditioning:
  - SEG and AN pass through 2-FF synchronizers.
  - Polarity is then normalised to active-high using SEG_ACT_LOW and AN_ACT_LOW.
- Decode, active-high a..g to value:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other pattern decodes to 4'hF and sets the frame error flag.
- FSM:
  - IDLE: normalised AN not one-hot (zero or multi-hot) → stay. One-hot → load settle counter with 0, go SETTLE.
  - SETTLE: counter increments each cycle that {AN,SEG} equals the previous cycle. Any change → counter restarts at 0. AN leaving one-hot → IDLE. Counter reaches SETTLE-1 → go CAPTURE.
  - CAPTURE (1 cycle): decoded value written to the shadow register of digit i; mask bit i set; go HOLD.
  - HOLD: wait until {AN,SEG} changes, then go IDLE. The same digit is never captured twice per dwell.
- Frame completion:
  - The cycle after the mask becomes 4'b1111: shadow copied to DIGITOS, ERR takes the frame error flag, VALID=1 for exactly 1 cycle.
  - In that same cycle the mask and frame error flag are cleared.
- Recapture: a digit recaptured before the frame completes overwrites its shadow value (latest wins). The mask is unchanged.
- Latency: 2 sync + SETTLE + 1 capture + 1 publish cycles from the last digit's stable onset to VALID.
- Simultaneous reset and frame completion: reset wins.

Optional Feature:
- Macro: DISPLAY_CAPTURE_TIMEOUT_EN.
- Defined:
  - A watchdog counter increments every cycle and clears on VALID.
  - On reaching TIMEOUT-1: STALL=1 (sticky), capture mask cleared, counter wraps to 0.
  - STALL clears on the next VALID or on reset.
- Undefined: STALL tied 0; TIMEOUT and TO_BITS unused; no watchdog logic synthesised.

Test Plan:
- Bench configuration: SETTLE=4, active-low buses.
- Test 1, nominal scan. Stimulus: scan digits 3,2,1,0 showing 5,9,4,7, each held 10 cycles. Required: one VALID pulse, DIGITOS=16'h5947, ERR=0.
- Test 2, glitch rejection. Stimulus: hold digit 0 for 3 cycles, then toggle one segment. Required: no capture. After the pattern is re-held 6 cycles, capture proceeds.
- Test 3, bad pattern. Stimulus: present SEG pattern 0000001 (g only) on digit 1 within an otherwise valid frame. Required: VALID with DIGITOS[7:4]=4'hF, ERR=1. Next clean frame gives ERR=0.
- Test 4, multi-hot anodes. Stimulus: assert AN=4'b0011 (active) for 20 cycles. Required: no capture, mask unchanged, no VALID.
- Test 5, reset mid-frame. Stimulus: pull RST low after 2 digits are captured. Required: outputs go to 0 immediately. The following full scan yields exactly one VALID with fresh values.
- Test 6, watchdog. Stimulus: with DISPLAY_CAPTURE_TIMEOUT_EN defined and TIMEOUT=50, hold AN idle for 60 cycles. Required: STALL=1 at cycle 49 after reset release; cleared by the next VALID.
